sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter EXPECTED_ID, default 32'h0000_0000, SHALL set the expected system ID word.
REQ-003 Parameter EXPECTED_TIMESTAMP, default 32'h50A7_A4D9, SHALL set the expected build timestamp word.
REQ-004 Parameter READ_LATENCY, default 0, legal range 0..3, SHALL give the fixed slave read latency in cycles.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run a check
- sysid_address  out  1  slave word select (0 = ID, 1 = timestamp)
- sysid_read  out  1  read strobe to the sysid control slave
- sysid_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check completes
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- pass  out  1  id_ok AND ts_ok
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Function
REQ-006 All outputs SHALL be registered.
REQ-007 The FSM SHALL have the states IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS and FIN.
REQ-008 In IDLE with start=1 at cycle T, the block SHALL enter RD_ID and clear id_ok, ts_ok and pass.
- At T+1: busy=1, sysid_read=1, sysid_address=0.
REQ-009 sysid_read SHALL be high for exactly one cycle per word.
- sysid_address SHALL hold its value from the read cycle until that word is sampled.
REQ-010 sysid_readdata SHALL be sampled exactly READ_LATENCY cycles after the read cycle; with READ_LATENCY=0 it is sampled in the read cycle itself.
REQ-011 WAIT_ID and WAIT_TS SHALL use a 2-bit down-counter loaded with READ_LATENCY; these states are skipped when READ_LATENCY=0.
REQ-012 The ID sample SHALL load id_value and set id_ok = (sample == EXPECTED_ID).
- The next cycle SHALL issue the timestamp read with sysid_address=1.
REQ-013 The timestamp sample SHALL load ts_value and set ts_ok.
- The FSM then enters FIN.
REQ-014 FIN SHALL last one cycle, pulse done=1, update pass, deassert busy and return to IDLE.
REQ-015 The cycle from start to done SHALL be T+3+2*READ_LATENCY.
REQ-016 start SHALL be ignored while busy=1 and during the FIN cycle.
REQ-017 id_value, ts_value, id_ok, ts_ok and pass SHALL hold their values until the next accepted start or reset.
REQ-018 The comparisons SHALL be full 32-bit equality; there are no masked or partial matches.

Reset
REQ-019 On reset all of the following SHALL be 0, and the FSM SHALL be in IDLE: busy, done, sysid_read, sysid_address, id_ok, ts_ok, pass, id_value, ts_value.
REQ-020 Reset asserted mid-check SHALL abort the check in the same cycle, with no done pulse and no partial result retained.
REQ-021 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-022 With SYSID_CHECKER_AUTOSTART_EN defined, the block SHALL start a check automatically in the first cycle reset is low after every reset, exactly as if start=1.
REQ-023 Without SYSID_CHECKER_AUTOSTART_EN, a check SHALL start only on start.
- Port list and timing SHALL be identical in both builds.

Verification
REQ-024 The bench SHALL cover a match at READ_LATENCY=0:
- Stimulus: slave returns 0 for address 0 and 32'h50A7A4D9 for address 1; start pulse at cycle 10.
- Response: done at cycle 13; pass=1, id_ok=1, ts_ok=1.
REQ-025 The bench SHALL cover a timestamp mismatch at READ_LATENCY=2:
- Stimulus: address 1 returns 32'h50A7A4D8.
- Response: done at T+7; id_ok=1, ts_ok=0, pass=0, ts_value=32'h50A7A4D8.
REQ-026 The bench SHALL cover start while busy:
- Stimulus: second start pulse at T+2.
- Response: exactly one done pulse and exactly two read strobes.
REQ-027 The bench SHALL cover reset mid-check:
- Stimulus: reset asserted at T+2 with READ_LATENCY=1.
- Response: next cycle busy=0, sysid_read=0, id_value=0; no done pulse.
REQ-028 The bench SHALL cover autostart with SYSID_CHECKER_AUTOSTART_EN defined:
- Stimulus: reset released at cycle 5, start held 0.
- Response: read strobe at cycle 6 and done at cycle 8 (READ_LATENCY=0).
REQ-029 The bench SHALL cover back-to-back checks:
- Stimulus: a new start in the cycle after done.
- Response: the new check is accepted, and id_ok/ts_ok/pass read 0 until its samples arrive.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: reads ID and timestamp words from the sysid slave and compares them.
// Optional SYSID_CHECKER_AUTOSTART_EN launches a check on the first cycle after reset.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h50A7_A4D9,
  parameter int unsigned READ_LATENCY       = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    FIN
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        read_q;
  logic        addr_q;
  logic        id_ok_q;
  logic        ts_ok_q;
  logic        pass_q;
  logic [31:0] id_q;
  logic [31:0] ts_q;

  logic        go_d;
  logic        id_hit_d;
  logic        ts_hit_d;
  logic        id_smp_d;
  logic        ts_smp_d;

  assign id_hit_d = (sysid_readdata == EXPECTED_ID);
  assign ts_hit_d = (sysid_readdata == EXPECTED_TIMESTAMP);

  // The word is sampled in the read cycle itself, or on the last wait cycle.
  assign id_smp_d = (state_q == RD_ID && LAT == 2'd0) ||
                    (state_q == WAIT_ID && cnt_q == 2'd1);
  assign ts_smp_d = (state_q == RD_TS && LAT == 2'd0) ||
                    (state_q == WAIT_TS && cnt_q == 2'd1);

`ifdef SYSID_CHECKER_AUTOSTART_EN
  logic auto_q;

  always_ff @(posedge clock) begin
    auto_q <= reset;
  end

  assign go_d = start | auto_q;
`else
  assign go_d = start;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      pass_q  <= 1'b0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      read_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go_d) begin
            state_q <= RD_ID;
            busy_q  <= 1'b1;
            read_q  <= 1'b1;
            addr_q  <= 1'b0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        RD_ID, WAIT_ID: begin
          if (id_smp_d) begin
            id_q    <= sysid_readdata;
            id_ok_q <= id_hit_d;
            state_q <= RD_TS;
            read_q  <= 1'b1;
            addr_q  <= 1'b1;
          end else if (state_q == RD_ID) begin
            state_q <= WAIT_ID;
            cnt_q   <= LAT;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RD_TS, WAIT_TS: begin
          if (ts_smp_d) begin
            ts_q    <= sysid_readdata;
            ts_ok_q <= ts_hit_d;
            pass_q  <= id_ok_q & ts_hit_d;
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            addr_q  <= 1'b0;
          end else if (state_q == RD_TS) begin
            state_q <= WAIT_TS;
            cnt_q   <= LAT;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sysid_address = addr_q;
  assign sysid_read    = read_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign pass          = pass_q;
  assign id_value      = id_q;
  assign ts_value      = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: four checkers (latency 0..3) against latency-exact slave
// models, with a scoreboard fed by a cycle-level reference model.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h50A7_A4D9;
`ifdef SYSID_CHECKER_AUTOSTART_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  typedef struct {
    int          c;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        iok;
    logic        tok;
    logic        ps;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy_w [4];
  logic        done_w [4];
  logic        read_w [4];
  logic        addr_w [4];
  logic        iok_w  [4];
  logic        tok_w  [4];
  logic        pass_w [4];
  logic [31:0] rdata_w[4];
  logic [31:0] idv_w  [4];
  logic [31:0] tsv_w  [4];

  logic [31:0] id_word;
  logic [31:0] ts_word;
  logic [31:0] junk;
  logic        rst_d;
  int          cyc = 0;

  exp_t sb[4][32];
  int   wr_i[4];
  int   rd_i[4];
  int   last_done[4];
  int   clr_at[4];
  int   rdcnt[4];
  int   dncnt[4];
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_rst = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
    junk  <= $urandom | 32'h1;
  end

  function automatic void chk(input string nm, input int g,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s L%0d: got %h expected %h", nm, g, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [3:0]  pv;
    logic [3:0]  pa;
    logic [2:0]  pvq;
    logic [2:0]  paq;
    logic [31:0] word;

    // Slave: valid data only exactly g cycles after the strobe, same address.
    assign pv   = {pvq, read_w[g]};
    assign pa   = {paq, addr_w[g]};
    assign word = addr_w[g] ? ts_word : id_word;
    assign rdata_w[g] = (pv[g] && addr_w[g] == pa[g]) ? word : word ^ junk;

    always @(posedge clk) begin
      pvq <= pv[2:0];
      paq <= pa[2:0];
    end

    sysid_checker #(
      .READ_LATENCY(g)
    ) u_dut (
      .clock         (clk),
      .reset         (reset),
      .start         (start),
      .sysid_address (addr_w[g]),
      .sysid_read    (read_w[g]),
      .sysid_readdata(rdata_w[g]),
      .busy          (busy_w[g]),
      .done          (done_w[g]),
      .id_ok         (iok_w[g]),
      .ts_ok         (tok_w[g]),
      .pass          (pass_w[g]),
      .id_value      (idv_w[g]),
      .ts_value      (tsv_w[g])
    );

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (read_w[g]) rdcnt[g]++;
        if (done_w[g]) dncnt[g]++;
        if (rst_d === 1'b1) begin
          chk("rst_busy", g, busy_w[g], 0);
          chk("rst_done", g, done_w[g], 0);
          chk("rst_read", g, read_w[g], 0);
          chk("rst_addr", g, addr_w[g], 0);
          chk("rst_id_ok", g, iok_w[g], 0);
          chk("rst_ts_ok", g, tok_w[g], 0);
          chk("rst_pass", g, pass_w[g], 0);
          chk("rst_id_value", g, idv_w[g], 0);
          chk("rst_ts_value", g, tsv_w[g], 0);
        end
        if (clr_at[g] == cyc) begin
          chk("acc_busy", g, busy_w[g], 1);
          chk("acc_read", g, read_w[g], 1);
          chk("acc_addr", g, addr_w[g], 0);
          chk("acc_id_ok", g, iok_w[g], 0);
          chk("acc_ts_ok", g, tok_w[g], 0);
          chk("acc_pass", g, pass_w[g], 0);
        end
        while (rd_i[g] != wr_i[g] && sb[g][rd_i[g] % 32].c < cyc) begin
          chk("done_missed", g, 32'(cyc), 32'(sb[g][rd_i[g] % 32].c));
          rd_i[g]++;
        end
        if (done_w[g]) begin
          if (rd_i[g] == wr_i[g]) begin
            chk("unexpected_done", g, done_w[g], 0);
          end else begin
            e = sb[g][rd_i[g] % 32];
            rd_i[g]++;
            chk("done_cycle", g, 32'(cyc), 32'(e.c));
            chk("id_value", g, idv_w[g], e.idv);
            chk("ts_value", g, tsv_w[g], e.tsv);
            chk("id_ok", g, iok_w[g], e.iok);
            chk("ts_ok", g, tok_w[g], e.tok);
            chk("pass", g, pass_w[g], e.ps);
            chk("fin_busy", g, busy_w[g], 0);
          end
        end
      end
    end
  end

  // Reference model: a check is accepted when the checker has finished its
  // previous FIN cycle; done follows 3 + 2*latency cycles later.
  task automatic model(input logic s, input logic r);
    exp_t e;
    logic go;
    go = s || (AUTO && prev_rst && !r);
    for (int g = 0; g < 4; g++) begin
      if (r) begin
        while (wr_i[g] != rd_i[g] && sb[g][(wr_i[g] - 1) % 32].c > cyc)
          wr_i[g]--;
        last_done[g] = -1;
      end else if (go && cyc > last_done[g]) begin
        e.c   = cyc + 3 + 2 * g;
        e.idv = id_word;
        e.tsv = ts_word;
        e.iok = (id_word == EXP_ID);
        e.tok = (ts_word == EXP_TS);
        e.ps  = e.iok && e.tok;
        sb[g][wr_i[g] % 32] = e;
        wr_i[g]++;
        last_done[g] = e.c;
        clr_at[g] = cyc + 1;
      end
    end
    prev_rst = r;
  endtask

  task automatic step(input logic s, input logic r);
    start = s;
    reset = r;
    model(s, r);
    @(posedge clk);
    #1;
  endtask

  int r0[4];
  int d0[4];

  initial begin
    for (int g = 0; g < 4; g++) begin
      wr_i[g] = 0;
      rd_i[g] = 0;
      last_done[g] = -1;
      clr_at[g] = -1;
      rdcnt[g] = 0;
      dncnt[g] = 0;
    end
    id_word = EXP_ID;
    ts_word = EXP_TS;
    start = 1'b0;
    reset = 1'b1;

    repeat (5) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int g = 0; g < 4; g++)
      chk("autostart_busy", g, busy_w[g], AUTO);
    repeat (4) step(1'b0, 1'b0);

    // Matching words, start at cycle 10
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    // Timestamp off by one
    ts_word = 32'h50A7_A4D8;
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    // Second start while busy
    id_word = $urandom | 32'h1000;
    ts_word = EXP_TS;
    for (int g = 0; g < 4; g++) begin
      r0[g] = rdcnt[g];
      d0[g] = dncnt[g];
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      chk("busy_start_reads", g, 32'(rdcnt[g] - r0[g]), 2);
      chk("busy_start_dones", g, 32'(dncnt[g] - d0[g]), 1);
    end

    // Reset two cycles into a check
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0);

    // Start held high: back-to-back checks
    id_word = EXP_ID;
    ts_word = EXP_TS;
    repeat (25) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    // Randomized rounds
    for (int k = 0; k < 40; k++) begin
      id_word = ($urandom % 2 == 0) ? EXP_ID : ($urandom | 32'h1);
      ts_word = ($urandom % 2 == 0) ? EXP_TS :
                (EXP_TS ^ (32'h1 << ($urandom % 32)));
      for (int j = 0; j < 12; j++)
        step(($urandom % 3) == 0, ($urandom % 30) == 0);
      repeat (12) step(1'b0, 1'b0);
    end

    for (int g = 0; g < 4; g++)
      chk("pending_checks", g, 32'(wr_i[g] - rd_i[g]), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
